// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a one-cycle dead handover between owners and an owner-selected address/data mux.
// Optional per-tenure burst limit is compiled in with `define BUS_ARB_BURST_LIMIT_EN.
module bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BURST   = 8,
  localparam int OWNER_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        req_in,
  input  logic [NUM_MASTERS-1:0]        lock_in,
  input  logic [NUM_MASTERS*ADDR_W-1:0] addr_in,
  input  logic [NUM_MASTERS*DATA_W-1:0] wdata_in,
  input  logic [NUM_MASTERS-1:0]        rw_in,
  output logic [NUM_MASTERS-1:0]        grant_out,
  output logic [NUM_MASTERS-1:0]        hold_out,
  output logic [ADDR_W-1:0]             addr_out,
  output logic [DATA_W-1:0]             wdata_out,
  output logic                          rw_out,
  output logic                          valid_out,
  output logic [OWNER_W-1:0]            owner_out,
  output logic                          busy_out
);

  typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} state_t;

  state_t                   state_q, state_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic [OWNER_W-1:0]       owner_q, owner_d;
  logic [OWNER_W-1:0]       ptr_q, ptr_d;
  logic [OWNER_W-1:0]       winner;
  logic [OWNER_W-1:0]       scan_idx;
  logic                     win_found;
  logic                     any_req;
  logic                     others_req;
  logic                     release_req;
  logic                     burst_force;
  logic [NUM_MASTERS-1:0]   owner_onehot;

  logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i]  = addr_in[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = wdata_in[i*DATA_W +: DATA_W];
  end

  // Round-robin scan starting at ptr; first requester found wins.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      scan_idx = OWNER_W'((int'(ptr_q) + k) % NUM_MASTERS);
      if (!win_found && req_in[scan_idx]) begin
        win_found = 1'b1;
        winner    = scan_idx;
      end
    end
  end

  assign any_req      = |req_in;
  assign owner_onehot = NUM_MASTERS'(1) << owner_q;
  assign others_req   = |(req_in & ~owner_onehot);
  assign release_req  = !req_in[owner_q] || (!lock_in[owner_q] && others_req) || burst_force;

`ifdef BUS_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts cycles already granted this tenure, so MAX_BURST-1 marks the last allowed cycle.
  assign burst_force = (cnt_q >= CNT_W'(MAX_BURST - 1)) && others_req;
`else
  assign burst_force = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef BUS_ARB_BURST_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE, HANDOVER: begin
        if (any_req) begin
          state_d = GRANT;
          grant_d = NUM_MASTERS'(1) << winner;
          owner_d = winner;
`ifdef BUS_ARB_BURST_LIMIT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
`ifdef BUS_ARB_BURST_LIMIT_EN
        if (cnt_q != CNT_W'(MAX_BURST)) cnt_d = cnt_q + 1'b1;
`endif
        if (release_req) begin
          state_d = HANDOVER;
          grant_d = '0;
          ptr_d   = (owner_q == OWNER_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
`ifdef BUS_ARB_BURST_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
`ifdef BUS_ARB_BURST_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant_out = grant_q;
  assign owner_out = owner_q;
  assign busy_out  = (state_q != IDLE);
  assign hold_out  = req_in & ~grant_q;
  assign valid_out = (state_q == GRANT) && req_in[owner_q];

  // Bus lines are zeroed outside GRANT so nothing is driven during the dead cycle.
  always_comb begin
    addr_out  = '0;
    wdata_out = '0;
    rw_out    = 1'b0;
    if (state_q == GRANT) begin
      addr_out  = addr_arr[owner_q];
      wdata_out = wdata_arr[owner_q];
      rw_out    = rw_in[owner_q];
    end
  end

endmodule
